bp_nbf_stream_loader: RTL

BP_NBF_STREAM_LOADER -- requirements
Module: bp_nbf_stream_loader

---
 rtl/bp_nbf_stream_loader.sv | 135 +++++++++++++
 1 files changed

// File: rtl/bp_nbf_stream_loader.sv
// NBF byte-stream loader: assembles 14-byte records into uncached 8-byte write commands with
// flow control on outstanding writes. Define BP_NBF_STREAM_CHECKSUM_EN to enable the XOR checksum.
module bp_nbf_stream_loader #(
  parameter int paddr_width_p     = 40,
  parameter int max_outstanding_p = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [7:0]               data_i,
  input  logic                     v_i,
  output logic                     ready_and_o,
  output logic [paddr_width_p-1:0] cmd_addr_o,
  output logic [63:0]              cmd_data_o,
  output logic                     cmd_v_o,
  input  logic                     cmd_yumi_i,
  input  logic                     resp_v_i,
  output logic                     resp_ready_and_o,
  output logic                     done_o,
  output logic                     error_o,
  output logic [63:0]              checksum_o
);

  localparam int cnt_w = $clog2(max_outstanding_p + 1);
  localparam logic [cnt_w-1:0] cnt_max = cnt_w'(max_outstanding_p);

  typedef enum logic [2:0] {RECV, SEND, FENCE, DONE, ERROR} state_e;

  state_e           state;
  logic [3:0]       idx;
  logic             full;
  logic             final_q;
  logic             err;
  logic [111:0]     rec;
  logic [cnt_w-1:0] cnt;
  logic [cnt_w-1:0] cnt_nxt;
  logic             issue;
  logic             underflow;
  logic             accept;

  assign ready_and_o      = (state == RECV) && !full;
  assign resp_ready_and_o = 1'b1;
  assign cmd_v_o          = (state == SEND) && (cnt < cnt_max);
  assign done_o           = (state == DONE);
  assign error_o          = err;
  assign issue            = cmd_v_o & cmd_yumi_i;
  assign accept           = v_i & ready_and_o;

  // A simultaneous issue and response cancel; a response with nothing outstanding is an underflow.
  always_comb begin
    cnt_nxt   = cnt;
    underflow = 1'b0;
    if (issue && !resp_v_i) begin
      cnt_nxt = cnt + cnt_w'(1);
    end else if (!issue && resp_v_i) begin
      if (cnt == '0) underflow = 1'b1;
      else           cnt_nxt   = cnt - cnt_w'(1);
    end
  end

  // Bytes shift in from the top, so byte k of a complete record sits at rec[8k+7:8k].
  always_ff @(posedge clk_i) begin
    if (accept) rec <= {data_i, rec[111:8]};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= RECV;
      idx        <= '0;
      full       <= 1'b0;
      final_q    <= 1'b0;
      cnt        <= '0;
      err        <= 1'b0;
      cmd_addr_o <= '0;
      cmd_data_o <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (underflow) err <= 1'b1;
      case (state)
        RECV: begin
          if (full) begin
            full <= 1'b0;
            case (rec[7:0])
              8'h03: begin
                state      <= SEND;
                cmd_addr_o <= paddr_width_p'(rec[47:8]);
                cmd_data_o <= rec[111:48];
              end
              8'hFE: begin
                state   <= FENCE;
                final_q <= 1'b0;
              end
              8'hFF: begin
                state   <= FENCE;
                final_q <= 1'b1;
              end
              default: begin
                state <= ERROR;
                err   <= 1'b1;
              end
            endcase
          end else if (accept) begin
            if (idx == 4'd13) begin
              idx  <= '0;
              full <= 1'b1;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        SEND: begin
          if (issue) state <= RECV;
        end
        // Looking at the post-update count lets the fence release the cycle after the last response.
        FENCE: begin
          if (cnt_nxt == '0) state <= final_q ? DONE : RECV;
        end
        default: ;
      endcase
    end
  end

`ifdef BP_NBF_STREAM_CHECKSUM_EN
  logic [63:0] csum;

  always_ff @(posedge clk_i) begin
    if (reset_i)    csum <= '0;
    else if (issue) csum <= csum ^ cmd_data_o;
  end

  assign checksum_o = csum;
`else
  assign checksum_o = '0;
`endif

endmodule
